// File: rtl/axi_tdd_ng_channel_bank.sv
// axi_tdd_ng_channel_bank
// Bank of TDD output channels. Each channel combines up to NUM_WINDOWS
// on/off windows per frame, compared against the shared frame counter.
// Timing and polarity come from shadow registers, which track the asy_*
// inputs while tdd_enable is high.
// Pipeline: counter compare -> set/rst strobes -> window state -> output.
// Optional feature macro: AXI_TDD_NG_CH_FRAME_DIV_EN. When it is defined,
// each channel runs only in 1 of every frame_div+1 frames.

package axi_tdd_ng_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    WAITING = 2'd2,
    RUNNING = 2'd3
  } state_t;
endpackage

module axi_tdd_ng_channel_bank #(
  parameter int NUM_CHANNELS   = 8,
  parameter int NUM_WINDOWS    = 2,
  parameter int REGISTER_WIDTH = 32,
  parameter logic [NUM_CHANNELS-1:0] DEFAULT_POLARITY = '0
) (
  input  logic                                            clk,
  input  logic                                            resetn,
  input  logic [REGISTER_WIDTH-1:0]                       tdd_counter,
  input  axi_tdd_ng_pkg::state_t                          tdd_cstate,
  input  logic                                            tdd_enable,
  input  logic                                            tdd_endof_frame,
  input  logic [NUM_CHANNELS-1:0]                         ch_en,
  input  logic [NUM_CHANNELS-1:0]                         asy_ch_pol,
  input  logic [NUM_CHANNELS*NUM_WINDOWS*REGISTER_WIDTH-1:0] asy_t_on,
  input  logic [NUM_CHANNELS*NUM_WINDOWS*REGISTER_WIDTH-1:0] asy_t_off,
  input  logic [NUM_CHANNELS*NUM_WINDOWS-1:0]             asy_win_en,
`ifdef AXI_TDD_NG_CH_FRAME_DIV_EN
  input  logic [NUM_CHANNELS*8-1:0]                       asy_frame_div,
`endif
  output logic [NUM_CHANNELS-1:0]                         out
);

  localparam int NC = NUM_CHANNELS;
  localparam int NW = NUM_WINDOWS;
  localparam int RW = REGISTER_WIDTH;

  // Shadow registers
  logic [NC-1:0]       r_ch_pol;
  logic [NC*NW*RW-1:0] r_t_on;
  logic [NC*NW*RW-1:0] r_t_off;
  logic [NC*NW-1:0]    r_win_en;

  // Control and pipeline state
  logic [NC-1:0]    r_ch_en;
  logic [NC*NW-1:0] w_set_p0;
  logic [NC*NW-1:0] w_rst_p0;
  logic [NC*NW-1:0] r_set_p1;
  logic [NC*NW-1:0] r_rst_p1;
  logic [NC*NW-1:0] r_act_p2;
  logic [NC-1:0]    w_any_p2;
  logic [NC-1:0]    r_out_p3;
  logic [NC-1:0]    w_frame_ok;
  logic             w_running;

  assign w_running = (tdd_cstate == axi_tdd_ng_pkg::RUNNING);

  // Capture the asynchronous configuration while tdd_enable is high
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ch_pol <= '0;
      r_t_on   <= '0;
      r_t_off  <= '0;
      r_win_en <= '0;
    end else if (tdd_enable) begin
      r_ch_pol <= asy_ch_pol;
      r_t_on   <= asy_t_on;
      r_t_off  <= asy_t_off;
      r_win_en <= asy_win_en;
    end
  end

  // Channel enables change only in ARMED or on a frame boundary, so a
  // mid-frame ch_en edit never cuts a waveform short
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ch_en <= '0;
    end else if (tdd_cstate == axi_tdd_ng_pkg::IDLE) begin
      r_ch_en <= '0;
    end else if (tdd_cstate == axi_tdd_ng_pkg::ARMED || tdd_endof_frame) begin
      r_ch_en <= ch_en;
    end
  end

`ifdef AXI_TDD_NG_CH_FRAME_DIV_EN
  logic [NC*8-1:0] r_frame_div;
  logic [NC*8-1:0] r_fc;

  // Shadow the frame divider along with the other configuration
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_frame_div <= '0;
    end else if (tdd_enable) begin
      r_frame_div <= asy_frame_div;
    end
  end

  // Per-channel frame counter, wrapping after reaching its divider
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_fc <= '0;
    end else if (tdd_cstate == axi_tdd_ng_pkg::ARMED) begin
      r_fc <= '0;
    end else if (tdd_endof_frame) begin
      for (int c = 0; c < NC; c++) begin
        if (r_fc[c*8 +: 8] == r_frame_div[c*8 +: 8])
          r_fc[c*8 +: 8] <= 8'd0;
        else
          r_fc[c*8 +: 8] <= r_fc[c*8 +: 8] + 8'd1;
      end
    end
  end

  // A channel may open windows only in frames where its counter is zero
  always_comb begin
    w_frame_ok = '0;
    for (int c = 0; c < NC; c++)
      w_frame_ok[c] = (r_fc[c*8 +: 8] == 8'd0);
  end
`else
  // Every frame is active for every channel
  assign w_frame_ok = '1;
`endif

  // Compare the frame counter against each window's on/off times
  always_comb begin
    w_set_p0 = '0;
    w_rst_p0 = '0;
    for (int c = 0; c < NC; c++) begin
      for (int w = 0; w < NW; w++) begin
        w_set_p0[c*NW+w] = w_running && r_win_en[c*NW+w] && w_frame_ok[c] &&
                           (tdd_counter == r_t_on[(c*NW+w)*RW +: RW]);
        w_rst_p0[c*NW+w] = (w_running && r_win_en[c*NW+w] &&
                            (tdd_counter == r_t_off[(c*NW+w)*RW +: RW])) ||
                           tdd_endof_frame;
      end
    end
  end

  // ---- stage p0 -> p1: register set/rst strobes ----
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_set_p1 <= '0;
      r_rst_p1 <= '0;
    end else begin
      r_set_p1 <= w_set_p0;
      r_rst_p1 <= w_rst_p0;
    end
  end

  // ---- stage p1 -> p2: window state, reset wins over set ----
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_act_p2 <= '0;
    end else begin
      for (int c = 0; c < NC; c++) begin
        for (int w = 0; w < NW; w++) begin
          if (r_rst_p1[c*NW+w] || !r_ch_en[c])
            r_act_p2[c*NW+w] <= 1'b0;
          else if (r_set_p1[c*NW+w])
            r_act_p2[c*NW+w] <= 1'b1;
        end
      end
    end
  end

  // Overlapping windows OR together per channel
  always_comb begin
    w_any_p2 = '0;
    for (int c = 0; c < NC; c++)
      w_any_p2[c] = |r_act_p2[c*NW +: NW];
  end

  // ---- stage p2 -> p3: apply idle polarity and register the outputs ----
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_out_p3 <= DEFAULT_POLARITY;
    end else begin
      r_out_p3 <= r_ch_pol ^ w_any_p2;
    end
  end

  assign out = r_out_p3;

endmodule

// File: tb/tb_axi_tdd_ng_channel_bank.sv
// Directed testbench for axi_tdd_ng_channel_bank (8 channels, 2 windows).
// Channel roles: ch0 single window, ch1 two windows, ch2 overlap,
// ch3 window past frame end, ch4 ch_en dropped mid-frame, ch5 t_on==t_off,
// ch6 inverted polarity, ch7 disabled with polarity 1.
module tb_axi_tdd_ng_channel_bank;
  localparam int NC = 8;
  localparam int NW = 2;
  localparam int RW = 32;

  logic                   clk = 1'b0;
  logic                   resetn;
  logic [RW-1:0]          tdd_counter;
  axi_tdd_ng_pkg::state_t tdd_cstate;
  logic                   tdd_enable;
  logic                   tdd_endof_frame;
  logic [NC-1:0]          ch_en;
  logic [NC-1:0]          asy_ch_pol;
  logic [NC*NW*RW-1:0]    asy_t_on;
  logic [NC*NW*RW-1:0]    asy_t_off;
  logic [NC*NW-1:0]       asy_win_en;
`ifdef AXI_TDD_NG_CH_FRAME_DIV_EN
  logic [NC*8-1:0]        asy_frame_div;
`endif
  logic [NC-1:0]          out;

  logic [7:0] hist [0:12][0:63];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_tdd_ng_channel_bank #(
    .NUM_CHANNELS(NC), .NUM_WINDOWS(NW), .REGISTER_WIDTH(RW),
    .DEFAULT_POLARITY(8'hA5)
  ) dut (
    .clk(clk), .resetn(resetn), .tdd_counter(tdd_counter),
    .tdd_cstate(tdd_cstate), .tdd_enable(tdd_enable),
    .tdd_endof_frame(tdd_endof_frame), .ch_en(ch_en),
    .asy_ch_pol(asy_ch_pol), .asy_t_on(asy_t_on), .asy_t_off(asy_t_off),
    .asy_win_en(asy_win_en),
`ifdef AXI_TDD_NG_CH_FRAME_DIV_EN
    .asy_frame_div(asy_frame_div),
`endif
    .out(out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_win(input int c, input int w, input int on, input int off);
    asy_t_on[(c*NW+w)*RW +: RW]  = on;
    asy_t_off[(c*NW+w)*RW +: RW] = off;
    asy_win_en[c*NW+w]           = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      tdd_endof_frame = 1'b0;
    end
  endtask

  // One frame of counter values; out is sampled on the falling edge so
  // hist[f][i] is the output seen while the counter reads i
  task automatic run_frame(input int f, input int len, input int idle_at,
                           input int chg_at, input logic [7:0] chg_val);
    for (int i = 0; i < len; i++) begin
      @(posedge clk);
      #1;
      tdd_counter     = i;
      tdd_endof_frame = (i == len - 1);
      if (i == idle_at) tdd_cstate = axi_tdd_ng_pkg::IDLE;
      if (i == chg_at)  ch_en = chg_val;
      @(negedge clk);
      hist[f][i] = out;
    end
  endtask

  function automatic logic any_bit(input int f, input int b, input int len);
    logic r = 1'b0;
    for (int i = 0; i < len; i++) r = r | hist[f][i][b];
    return r;
  endfunction

  function automatic logic all_bit(input int f, input int b, input int len);
    logic r = 1'b1;
    for (int i = 0; i < len; i++) r = r & hist[f][i][b];
    return r;
  endfunction

  initial begin
    resetn          = 1'b0;
    tdd_counter     = '0;
    tdd_cstate      = axi_tdd_ng_pkg::IDLE;
    tdd_enable      = 1'b1;
    tdd_endof_frame = 1'b0;
    ch_en           = 8'h7F;
    asy_ch_pol      = 8'hC0;
    asy_t_on        = '0;
    asy_t_off       = '0;
    asy_win_en      = '0;
`ifdef AXI_TDD_NG_CH_FRAME_DIV_EN
    asy_frame_div   = '0;
`endif
    set_win(0, 0, 10, 20);
    set_win(1, 0, 5, 8);
    set_win(1, 1, 12, 15);
    set_win(2, 0, 5, 20);
    set_win(2, 1, 10, 12);
    set_win(3, 0, 10, 100);
    set_win(4, 0, 10, 20);
    set_win(5, 0, 7, 7);
    set_win(6, 0, 10, 20);
    set_win(7, 0, 10, 20);

    // Reset state
    wait_cycles(4);
    check_eq("reset_out", out, 8'hA5);
    check_eq("reset_set", dut.r_set_p1, 0);
    check_eq("reset_rst", dut.r_rst_p1, 0);
    check_eq("reset_act", dut.r_act_p2, 0);
    resetn = 1'b1;
    wait_cycles(3);
    check_eq("idle_pol", out, 8'hC0);

    // Arm, then three running frames of 50 counts
    tdd_cstate = axi_tdd_ng_pkg::ARMED;
    wait_cycles(2);
    tdd_cstate = axi_tdd_ng_pkg::RUNNING;
    run_frame(1, 50, 999, 999, 8'h00);
    run_frame(2, 50, 999, 5, 8'h6F);
    run_frame(3, 50, 999, 999, 8'h00);

    check_eq("ch0_c12", hist[1][12][0], 0);
    check_eq("ch0_c13", hist[1][13][0], 1);
    check_eq("ch0_c22", hist[1][22][0], 1);
    check_eq("ch0_c23", hist[1][23][0], 0);
    check_eq("ch1_c7",  hist[1][7][1], 0);
    check_eq("ch1_c8",  hist[1][8][1], 1);
    check_eq("ch1_c10", hist[1][10][1], 1);
    check_eq("ch1_c11", hist[1][11][1], 0);
    check_eq("ch1_c14", hist[1][14][1], 0);
    check_eq("ch1_c15", hist[1][15][1], 1);
    check_eq("ch1_c17", hist[1][17][1], 1);
    check_eq("ch1_c18", hist[1][18][1], 0);
    check_eq("ch2_c7",  hist[1][7][2], 0);
    check_eq("ch2_c8",  hist[1][8][2], 1);
    check_eq("ch2_c15", hist[1][15][2], 1);
    check_eq("ch2_c22", hist[1][22][2], 1);
    check_eq("ch2_c23", hist[1][23][2], 0);
    check_eq("ch3_c12", hist[1][12][3], 0);
    check_eq("ch3_c49", hist[1][49][3], 1);
    check_eq("ch3_eof0", hist[2][0][3], 1);
    check_eq("ch3_eof1", hist[2][1][3], 1);
    check_eq("ch3_eof2", hist[2][2][3], 0);
    check_eq("ch3_f2c13", hist[2][13][3], 1);
    check_eq("ch4_f2c13", hist[2][13][4], 1);
    check_eq("ch4_f3any", any_bit(3, 4, 50), 0);
    check_eq("ch5_f1any", any_bit(1, 5, 50), 0);
    check_eq("ch5_f2any", any_bit(2, 5, 50), 0);
    check_eq("ch6_c12", hist[1][12][6], 1);
    check_eq("ch6_c13", hist[1][13][6], 0);
    check_eq("ch6_c23", hist[1][23][6], 1);
    check_eq("ch7_f1all", all_bit(1, 7, 50), 1);
    check_eq("ch0_f3c13", hist[3][13][0], 1);

    // IDLE while windows are open
    ch_en = 8'h7F;
    tdd_cstate = axi_tdd_ng_pkg::ARMED;
    wait_cycles(2);
    tdd_cstate = axi_tdd_ng_pkg::RUNNING;
    run_frame(4, 25, 16, 999, 8'h00);
    check_eq("idle_c16", hist[4][16][0], 1);
    check_eq("idle_c18", hist[4][18][0], 1);
    check_eq("idle_c19", hist[4][19], 8'hC0);
    wait_cycles(4);
    check_eq("idle_after", out, 8'hC0);

    // Shadow hold and polarity tracking on disabled channels
    tdd_enable = 1'b0;
    asy_ch_pol = 8'hFF;
    wait_cycles(4);
    check_eq("shadow_hold", out, 8'hC0);
    tdd_enable = 1'b1;
    wait_cycles(4);
    check_eq("shadow_load", out, 8'hFF);
    asy_ch_pol = 8'hC0;
    wait_cycles(4);

`ifdef AXI_TDD_NG_CH_FRAME_DIV_EN
    // Frame divider of 2 on ch0: active in frames 0, 3, 6
    asy_frame_div[7:0] = 8'd2;
    ch_en = 8'h01;
    tdd_cstate = axi_tdd_ng_pkg::ARMED;
    wait_cycles(2);
    tdd_cstate = axi_tdd_ng_pkg::RUNNING;
    for (int f = 0; f < 7; f++) run_frame(5 + f, 30, 999, 999, 8'h01);
    for (int f = 0; f < 7; f++)
      check_eq($sformatf("fdiv_f%0d", f), hist[5+f][13][0], (f % 3 == 0) ? 1 : 0);
    wait_cycles(2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_tdd_ng_channel_bank.md
Name: axi_tdd_ng_channel_bank

Overview:
- Bank of NUM_CHANNELS TDD output channels, each driven by up to NUM_WINDOWS independent on/off windows per frame.
- Sits between the TDD frame counter/state machine and the TDD output pins.
- Replaces per-channel instantiation with one shared, shadow-registered block that adds multi-window waveforms and per-channel enable masking.

Parameters:
NUM_CHANNELS, 8, number of output channels (1..32)
NUM_WINDOWS, 2, on/off window pairs per channel (1..4)
REGISTER_WIDTH, 32, counter and timing register width
DEFAULT_POLARITY, '0, NUM_CHANNELS-bit reset value of out

Ports:
clk  input  1  clock
resetn  input  1  synchronous active-low reset
tdd_counter  input  REGISTER_WIDTH  frame counter
tdd_cstate  input  axi_tdd_ng_pkg::state_t  controller state (IDLE/ARMED/WAITING/RUNNING)
tdd_enable  input  1  shadow-capture enable
tdd_endof_frame  input  1  single-cycle end-of-frame strobe
ch_en  input  NUM_CHANNELS  per-channel enable (async domain, quasi-static)
asy_ch_pol  input  NUM_CHANNELS  per-channel idle polarity
asy_t_on  input  NUM_CHANNELS*NUM_WINDOWS*REGISTER_WIDTH  window on times, index [ch][win]
asy_t_off  input  NUM_CHANNELS*NUM_WINDOWS*REGISTER_WIDTH  window off times, same layout
asy_win_en  input  NUM_CHANNELS*NUM_WINDOWS  per-window enable
out  output  NUM_CHANNELS  channel outputs

Behaviour:
- Reset (resetn=0 at clk edge):
  - out=DEFAULT_POLARITY.
  - All shadow registers, channel enables and set/rst strobes cleared to 0.
- Shadow capture:
  - When tdd_enable=1, ch_pol, t_on, t_off and win_en shadow registers load from the asy_* inputs every cycle.
  - When tdd_enable=0, they hold.
- Channel enable (tdd_ch_en[c]):
  - Cleared when tdd_cstate==IDLE.
  - Loaded from ch_en[c] when tdd_cstate==ARMED or tdd_endof_frame=1.
  - Otherwise holds.
  - Mid-frame ch_en changes therefore take effect at the next frame boundary only.
- Window strobes, registered, 1 cycle after the compare:
  - set[c][w] = RUNNING && win_en[c][w] && tdd_counter==t_on[c][w].
  - rst[c][w] = (RUNNING && win_en[c][w] && tdd_counter==t_off[c][w]) || tdd_endof_frame.
- Window state:
  - act[c][w] is cleared on rst[c][w] or on !tdd_ch_en[c].
  - Otherwise act[c][w] is set on set[c][w].
  - If set and rst occur in the same cycle, rst wins.
  - If t_on==t_off, the window never asserts.
- Output:
  - out[c] = ch_pol[c] XOR (OR over w of act[c][w]), registered.
  - Total latency from counter match to out edge: 3 clk cycles (compare register, act register, out register).
- Window overlap:
  - Overlapping windows OR together.
  - A window closing inside another open window does not deassert out.
- Frame wrap: tdd_endof_frame clears all act bits, so out returns to ch_pol within 3 cycles, regardless of open windows.
- Disabled channel: out[c] = ch_pol[c] constantly (tracks shadow polarity).
- tdd_cstate leaving RUNNING mid-frame (e.g. to IDLE):
  - No further set strobes are generated.
  - IDLE clears tdd_ch_en, forcing out to polarity.
- Counter arithmetic: equality compare only, no wrap handling; t values beyond the frame length never match.

Optional Feature:
- Macro AXI_TDD_NG_CH_FRAME_DIV_EN.
- When defined:
  - Adds input asy_frame_div (NUM_CHANNELS*8 bits), shadowed like the other asy_* inputs.
  - Each channel has an 8-bit frame counter fc[c], cleared in ARMED and incremented on tdd_endof_frame.
  - fc[c] wraps to 0 after reaching frame_div[c].
  - Set strobes for channel c are generated only in frames where fc[c]==0, so the channel is active in 1 of every frame_div[c]+1 frames.
  - frame_div=0 behaves as the feature-less build.
- When undefined: no port, no counters; every enabled channel is active in every frame.

Test Plan:
- Reset check: DEFAULT_POLARITY=8'hA5, hold resetn=0 for 4 cycles -> out=8'hA5; all internal strobes 0.
- Single window: ch0 t_on=10, t_off=20, pol=0, ch_en=1, RUNNING -> out[0] rises when counter=13 and falls when counter=23.
- Two windows: ch1 w0=[5,8), w1=[12,15) -> two pulses per frame at counter 8..10 and 15..17. Overlap test w0=[5,20), w1=[10,12) -> single pulse 8..22.
- End of frame: t_off=100, frame length 50 -> out deasserts 3 cycles after tdd_endof_frame. Drop ch_en mid-frame -> channel still toggles until the next frame boundary, then stays at polarity.
- Same-cycle set and rst: t_on=t_off=7 -> out never leaves polarity. IDLE mid-window -> out returns to ch_pol in 3 cycles.
- FRAME_DIV_EN: frame_div=2 -> pulses appear in frames 0, 3, 6 only.
